// File: rtl/imm_gen_pipe_if.sv
// Bundle of the upstream (instruction in) and downstream (immediate out)
// handshakes of imm_gen_pipe. The slave modport is the generator's view,
// the master modport is the view of whoever drives and consumes it.
interface imm_gen_pipe_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 32,
   parameter int OP_W  = 3
);
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_inst;
   logic [OP_W-1:0]  in_op;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_imm;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       occupancy;

   modport slave (
      input  in_valid, in_inst, in_op, in_tag, out_ready,
      output in_ready, out_valid, out_imm, out_tag, occupancy
   );

   modport master (
      output in_valid, in_inst, in_op, in_tag, out_ready,
      input  in_ready, out_valid, out_imm, out_tag, occupancy
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// Registered RISC-V immediate generator with a 2-entry skid buffer.
// Handshake: a beat moves on a side only in a cycle where both its valid and
// ready are high at the rising edge; a producer holding valid must keep its
// payload unchanged until that happens, and valid never depends on ready.
// The buffer state (EMPTY/ONE/TWO) is exported directly as occupancy.
module imm_gen_pipe #(
   parameter int XLEN  = 32,   // 32 or 64
   parameter int TAG_W = 32,
   parameter int OP_W  = 3
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           flush,
   imm_gen_pipe_if.slave  bus
);

   localparam logic [OP_W-1:0] OP_I  = OP_W'(1);
   localparam logic [OP_W-1:0] OP_S  = OP_W'(2);
   localparam logic [OP_W-1:0] OP_B  = OP_W'(3);
   localparam logic [OP_W-1:0] OP_J  = OP_W'(4);
   localparam logic [OP_W-1:0] OP_U  = OP_W'(5);
   localparam logic [OP_W-1:0] OP_Z  = OP_W'(6);
   localparam logic [OP_W-1:0] OP_SH = OP_W'(7);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [XLEN-1:0]  main_imm_q, skid_imm_q;
   logic [TAG_W-1:0] main_tag_q, skid_tag_q;
   logic             main_load, main_from_skid, skid_load;
   logic             acc, pop;
   logic [63:0]      imm64;
   logic [XLEN-1:0]  imm_c;
   logic [31:0]      inst;

   assign inst = bus.in_inst;

   // Immediate formed at 64 bits; the low XLEN bits are the result, which
   // keeps the sign extension identical for RV32 and RV64.
   always_comb begin
      imm64 = 64'd0;
      case (bus.in_op)
         OP_I:  imm64 = {{52{inst[31]}}, inst[31:20]};
         OP_S:  imm64 = {{52{inst[31]}}, inst[31:25], inst[11:7]};
         OP_B:  imm64 = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                         inst[11:8], 1'b0};
         OP_J:  imm64 = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                         inst[30:21], 1'b0};
         OP_U:  imm64 = {{32{inst[31]}}, inst[31:12], 12'd0};
         OP_Z:  imm64 = {59'd0, inst[19:15]};
         OP_SH: imm64 = (XLEN == 64) ? {58'd0, inst[25:20]}
                                     : {59'd0, inst[24:20]};
         default: imm64 = 64'd0;
      endcase
   end

   assign imm_c = imm64[XLEN-1:0];

   generate
      if (XLEN < 64) begin : g_narrow
         logic unused_hi;
         assign unused_hi = ^imm64[63:XLEN];
      end
   endgenerate

   logic unused_opcode;
   assign unused_opcode = ^inst[6:0];

   assign bus.in_ready  = (state_q != ST_TWO);
   assign bus.out_valid = (state_q != ST_EMPTY);
   assign bus.out_imm   = main_imm_q;
   assign bus.out_tag   = main_tag_q;
   assign bus.occupancy = state_q;

   assign acc = bus.in_valid && bus.in_ready;
   assign pop = bus.out_valid && bus.out_ready;

   // Next-state and register load controls; flush overrides any transfer.
   always_comb begin
      state_d        = state_q;
      main_load      = 1'b0;
      main_from_skid = 1'b0;
      skid_load      = 1'b0;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  state_d   = ST_ONE;
                  main_load = 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && pop) begin
                  main_load = 1'b1;
               end else if (acc) begin
                  state_d   = ST_TWO;
                  skid_load = 1'b1;
               end else if (pop) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_d        = ST_ONE;
                  main_load      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Buffer state register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_EMPTY;
      else     state_q <= state_d;
   end

   // Main (output) register: loads only when an entry moves into it.
   always_ff @(posedge clk) begin
      if (rst) begin
         main_imm_q <= '0;
         main_tag_q <= '0;
      end else if (main_load) begin
         main_imm_q <= main_from_skid ? skid_imm_q : imm_c;
         main_tag_q <= main_from_skid ? skid_tag_q : bus.in_tag;
      end
   end

   // Skid register: catches the entry accepted while the output is stalled.
   always_ff @(posedge clk) begin
      if (rst) begin
         skid_imm_q <= '0;
         skid_tag_q <= '0;
      end else if (skid_load) begin
         skid_imm_q <= imm_c;
         skid_tag_q <= bus.in_tag;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: an RV32 and an RV64 instance driven with
// identical stimulus; 64-bit results are checked where they differ.
module tb_imm_gen_pipe;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   n_vec = 0;
   int   n_err = 0;

   imm_gen_pipe_if #(.XLEN(32), .TAG_W(32), .OP_W(3)) bus32 ();
   imm_gen_pipe_if #(.XLEN(64), .TAG_W(32), .OP_W(3)) bus64 ();

   imm_gen_pipe #(.XLEN(32), .TAG_W(32), .OP_W(3)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus32.slave));
   imm_gen_pipe #(.XLEN(64), .TAG_W(32), .OP_W(3)) dut64 (
      .clk(clk), .rst(rst), .flush(flush), .bus(bus64.slave));

   // clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] inst,
                        input logic [2:0] op, input logic [31:0] tag);
      bus32.in_valid = v; bus32.in_inst = inst; bus32.in_op = op; bus32.in_tag = tag;
      bus64.in_valid = v; bus64.in_inst = inst; bus64.in_op = op; bus64.in_tag = tag;
   endtask

   task automatic set_ready(input logic r);
      bus32.out_ready = r;
      bus64.out_ready = r;
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      set_ready(1'b0);
      tick(); tick();
      rst = 1'b0;
      n_vec++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", bus32.out_valid); end
      n_vec++; if (bus32.out_imm !== 32'd0) begin n_err++; $display("FAIL reset_imm got %h want 0", bus32.out_imm); end
      n_vec++; if (bus32.out_tag !== 32'd0) begin n_err++; $display("FAIL reset_tag got %h want 0", bus32.out_tag); end
      n_vec++; if (bus32.occupancy !== 2'd0) begin n_err++; $display("FAIL reset_occ got %0d want 0", bus32.occupancy); end
      n_vec++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %0b want 1", bus32.in_ready); end
      n_vec++; if (bus64.out_imm !== 64'd0) begin n_err++; $display("FAIL reset_imm64 got %h want 0", bus64.out_imm); end
   endtask

   // one-entry pass: accept, then check the registered result next cycle
   task automatic test_formats();
      logic [31:0] inst_t [11];
      logic [2:0]  op_t   [11];
      logic [31:0] e32_t  [11];
      logic [63:0] e64_t  [11];
      inst_t[0]  = 32'hFFF00093; op_t[0]  = 3'd1; e32_t[0]  = 32'hFFFFFFFF; e64_t[0]  = 64'hFFFFFFFFFFFFFFFF;
      inst_t[1]  = 32'hFE000EE3; op_t[1]  = 3'd3; e32_t[1]  = 32'hFFFFFFFC; e64_t[1]  = 64'hFFFFFFFFFFFFFFFC;
      inst_t[2]  = 32'h12345037; op_t[2]  = 3'd5; e32_t[2]  = 32'h12345000; e64_t[2]  = 64'h0000000012345000;
      inst_t[3]  = 32'h80000037; op_t[3]  = 3'd5; e32_t[3]  = 32'h80000000; e64_t[3]  = 64'hFFFFFFFF80000000;
      inst_t[4]  = 32'h000F8073; op_t[4]  = 3'd6; e32_t[4]  = 32'h0000001F; e64_t[4]  = 64'h000000000000001F;
      inst_t[5]  = 32'h03F09093; op_t[5]  = 3'd7; e32_t[5]  = 32'h0000001F; e64_t[5]  = 64'h000000000000003F;
      inst_t[6]  = 32'h80000FA3; op_t[6]  = 3'd2; e32_t[6]  = 32'hFFFFF81F; e64_t[6]  = 64'hFFFFFFFFFFFFF81F;
      inst_t[7]  = 32'h8000006F; op_t[7]  = 3'd4; e32_t[7]  = 32'hFFF00000; e64_t[7]  = 64'hFFFFFFFFFFF00000;
      inst_t[8]  = 32'h0020006F; op_t[8]  = 3'd4; e32_t[8]  = 32'h00000002; e64_t[8]  = 64'h0000000000000002;
      inst_t[9]  = 32'hFFFFFFFF; op_t[9]  = 3'd0; e32_t[9]  = 32'h00000000; e64_t[9]  = 64'h0000000000000000;
      inst_t[10] = 32'h7FF00093; op_t[10] = 3'd1; e32_t[10] = 32'h000007FF; e64_t[10] = 64'h00000000000007FF;
      set_ready(1'b1);
      for (int i = 0; i < 11; i++) begin
         drive(1'b1, inst_t[i], op_t[i], 32'h100 + i);
         tick();
         drive(1'b0, 32'd0, 3'd0, 32'd0);
         n_vec++; if (bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL fmt%0d_valid got %0b want 1", i, bus32.out_valid); end
         n_vec++; if (bus32.out_imm !== e32_t[i]) begin n_err++; $display("FAIL fmt%0d_imm32 got %h want %h", i, bus32.out_imm, e32_t[i]); end
         n_vec++; if (bus64.out_imm !== e64_t[i]) begin n_err++; $display("FAIL fmt%0d_imm64 got %h want %h", i, bus64.out_imm, e64_t[i]); end
         n_vec++; if (bus32.out_tag !== 32'h100 + i) begin n_err++; $display("FAIL fmt%0d_tag got %h want %h", i, bus32.out_tag, 32'h100 + i); end
      end
      tick();
      n_vec++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL fmt_drain_valid got %0b want 0", bus32.out_valid); end
   endtask

   // three entries against a stalled output, then release
   task automatic test_backpressure();
      logic [31:0] stall_imm;
      set_ready(1'b0);
      drive(1'b1, (32'd1 << 20) | 32'h13, 3'd1, 32'd1);
      tick();
      n_vec++; if (bus32.occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ1 got %0d want 1", bus32.occupancy); end
      n_vec++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready1 got %0b want 1", bus32.in_ready); end
      drive(1'b1, (32'd2 << 20) | 32'h13, 3'd1, 32'd2);
      tick();
      n_vec++; if (bus32.occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ2 got %0d want 2", bus32.occupancy); end
      n_vec++; if (bus32.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready2 got %0b want 0", bus32.in_ready); end
      drive(1'b1, (32'd3 << 20) | 32'h13, 3'd1, 32'd3);
      for (int c = 0; c < 3; c++) begin
         tick();
         stall_imm = bus32.out_imm;
         n_vec++; if (bus32.out_tag !== 32'd1) begin n_err++; $display("FAIL bp_stall%0d_tag got %0d want 1", c, bus32.out_tag); end
         n_vec++; if (stall_imm !== 32'd1) begin n_err++; $display("FAIL bp_stall%0d_imm got %h want 1", c, stall_imm); end
         n_vec++; if (bus32.occupancy !== 2'd2) begin n_err++; $display("FAIL bp_stall%0d_occ got %0d want 2", c, bus32.occupancy); end
      end
      set_ready(1'b1);
      tick();
      n_vec++; if (bus32.out_tag !== 32'd2 || bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out2 got tag %0d v %0b want tag 2 v 1", bus32.out_tag, bus32.out_valid); end
      n_vec++; if (bus32.out_imm !== 32'd2) begin n_err++; $display("FAIL bp_out2_imm got %h want 2", bus32.out_imm); end
      n_vec++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_after got %0b want 1", bus32.in_ready); end
      tick();
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      n_vec++; if (bus32.out_tag !== 32'd3 || bus32.out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out3 got tag %0d v %0b want tag 3 v 1", bus32.out_tag, bus32.out_valid); end
      n_vec++; if (bus32.occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ_out3 got %0d want 1", bus32.occupancy); end
      tick();
      n_vec++; if (bus32.out_valid !== 1'b0 || bus32.occupancy !== 2'd0) begin n_err++; $display("FAIL bp_drain got v %0b occ %0d want v 0 occ 0", bus32.out_valid, bus32.occupancy); end
   endtask

   // flush with a full buffer and with a same-cycle accept into ONE
   task automatic test_flush();
      set_ready(1'b0);
      drive(1'b1, 32'h00A00013, 3'd1, 32'd10); tick();
      drive(1'b1, 32'h00B00013, 3'd1, 32'd11); tick();
      n_vec++; if (bus32.occupancy !== 2'd2) begin n_err++; $display("FAIL fl_fill got %0d want 2", bus32.occupancy); end
      drive(1'b1, 32'h00C00013, 3'd1, 32'd12);
      flush = 1'b1; tick(); flush = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      n_vec++; if (bus32.out_valid !== 1'b0 || bus32.occupancy !== 2'd0) begin n_err++; $display("FAIL fl_full got v %0b occ %0d want v 0 occ 0", bus32.out_valid, bus32.occupancy); end
      n_vec++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL fl_ready got %0b want 1", bus32.in_ready); end
      drive(1'b1, 32'h00D00013, 3'd1, 32'd13); tick();
      drive(1'b1, 32'h00E00013, 3'd1, 32'd14);
      flush = 1'b1; tick(); flush = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      set_ready(1'b1);
      n_vec++; if (bus32.out_valid !== 1'b0 || bus32.occupancy !== 2'd0) begin n_err++; $display("FAIL fl_one got v %0b occ %0d want v 0 occ 0", bus32.out_valid, bus32.occupancy); end
      tick();
      n_vec++; if (bus32.out_valid !== 1'b0) begin n_err++; $display("FAIL fl_dropped got v %0b tag %0d want v 0", bus32.out_valid, bus32.out_tag); end
      drive(1'b1, 32'h00F00013, 3'd1, 32'd15); tick();
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      n_vec++; if (bus32.out_valid !== 1'b1 || bus32.out_tag !== 32'd15 || bus32.out_imm !== 32'd15) begin n_err++; $display("FAIL fl_after got v %0b tag %0d imm %h want v 1 tag 15 imm f", bus32.out_valid, bus32.out_tag, bus32.out_imm); end
      tick();
   endtask

   // reset while full clears data as well as control
   task automatic test_reset_mid();
      set_ready(1'b0);
      drive(1'b1, 32'h01500013, 3'd1, 32'd21); tick();
      drive(1'b1, 32'h01600013, 3'd1, 32'd22); tick();
      drive(1'b0, 32'd0, 3'd0, 32'd0);
      n_vec++; if (bus32.occupancy !== 2'd2) begin n_err++; $display("FAIL rm_fill got %0d want 2", bus32.occupancy); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_vec++; if (bus32.out_valid !== 1'b0 || bus32.occupancy !== 2'd0) begin n_err++; $display("FAIL rm_ctrl got v %0b occ %0d want v 0 occ 0", bus32.out_valid, bus32.occupancy); end
      n_vec++; if (bus32.out_imm !== 32'd0 || bus32.out_tag !== 32'd0) begin n_err++; $display("FAIL rm_data got imm %h tag %h want 0 0", bus32.out_imm, bus32.out_tag); end
      n_vec++; if (bus32.in_ready !== 1'b1) begin n_err++; $display("FAIL rm_ready got %0b want 1", bus32.in_ready); end
   endtask

   initial begin
      test_reset();
      test_formats();
      test_backpressure();
      test_flush();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
